// File: rtl/steer_sched.sv
// steer_sched: four-slot steering scheduler for a dual-rail (DATA/NULL) datapath.
// Grants one slot at a time. It waits for the DATA acknowledge, then for the NULL
// acknowledge, and only then moves the round-robin pointer on. A stuck handshake
// ends in a sticky error state that only init clears.
module steer_sched #(
  parameter int unsigned TMO         = 255,
  parameter bit          FIXED_ORDER = 1'b0
) (
  input  logic       clk,
  input  logic       init,
  input  logic [3:0] req,
  input  logic       steerCOMP,
  output logic [3:0] steer,
  output logic [1:0] owner,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    NULLW = 2'd2,
    ERR   = 2'd3
  } state_t;

  localparam logic [15:0] TMO_LIMIT = 16'(TMO);

  state_t      state;
  logic [1:0]  ptr;
  logic [15:0] tmo_cnt;

  logic [3:0]  req_rot;
  logic [1:0]  rr_offset;
  logic        rr_found;
  logic [1:0]  grant_idx;
  logic        grant_ok;
  logic [3:0]  grant_onehot;
  logic        tmo_hit;

  // Rotate the request vector so bit 0 is the slot the pointer currently favours.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    assign req_rot[gi] = req[2'(ptr + 2'(gi))];
  end

  // Find the first requester at or above the pointer (modulo 4).
  always_comb begin
    rr_found  = 1'b1;
    rr_offset = 2'd0;
    if (req_rot[0])      rr_offset = 2'd0;
    else if (req_rot[1]) rr_offset = 2'd1;
    else if (req_rot[2]) rr_offset = 2'd2;
    else if (req_rot[3]) rr_offset = 2'd3;
    else                 rr_found  = 1'b0;
  end

  // In fixed-order mode the pointer alone selects the slot and req is ignored.
  assign grant_idx = FIXED_ORDER ? ptr : 2'(ptr + rr_offset);
  assign grant_ok  = FIXED_ORDER ? 1'b1 : rr_found;

  // Decode the chosen index to the one-hot steering pattern.
  for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
    assign grant_onehot[gi] = (grant_idx == 2'(gi));
  end

  // The counter holds the number of cycles already spent waiting in this phase.
  assign tmo_hit = (tmo_cnt == TMO_LIMIT);

  // Handshake state machine; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (init) begin
      state   <= IDLE;
      steer   <= 4'd0;
      owner   <= 2'd0;
      ptr     <= 2'd0;
      busy    <= 1'b0;
      err     <= 1'b0;
      tmo_cnt <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          steer <= 4'd0;
          // A high steerCOMP here means the datapath still holds stale DATA.
          if (!steerCOMP && grant_ok) begin
            state   <= DATA;
            steer   <= grant_onehot;
            owner   <= grant_idx;
            busy    <= 1'b1;
            tmo_cnt <= 16'd0;
          end
        end
        DATA: begin
          // The acknowledge wins over a timeout that expires on the same edge.
          if (steerCOMP) begin
            state   <= NULLW;
            steer   <= 4'd0;
            tmo_cnt <= 16'd0;
          end else if (tmo_hit) begin
            state <= ERR;
            steer <= 4'd0;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            tmo_cnt <= 16'(tmo_cnt + 16'd1);
          end
        end
        NULLW: begin
          steer <= 4'd0;
          if (!steerCOMP) begin
            state <= IDLE;
            busy  <= 1'b0;
            ptr   <= 2'(owner + 2'd1);
          end else if (tmo_hit) begin
            state <= ERR;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            tmo_cnt <= 16'(tmo_cnt + 16'd1);
          end
        end
        ERR: begin
          steer <= 4'd0;
          busy  <= 1'b0;
          err   <= 1'b1;
        end
        default: begin
          state <= ERR;
          steer <= 4'd0;
          busy  <= 1'b0;
          err   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_steer_sched.sv
// tb_steer_sched: vector table, directed handshake sequences and a randomized
// run against a transaction-level reference model, on three parameterisations.
module tb_steer_sched;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dut_a: defaults; dut_b: short timeout; dut_c: fixed rotation
  logic       a_init, a_comp, a_busy, a_err;
  logic [3:0] a_req, a_steer;
  logic [1:0] a_owner;
  logic       b_init, b_comp, b_busy, b_err;
  logic [3:0] b_req, b_steer;
  logic [1:0] b_owner;
  logic       c_init, c_comp, c_busy, c_err;
  logic [3:0] c_req, c_steer;
  logic [1:0] c_owner;

  steer_sched dut_a (
    .clk(clk), .init(a_init), .req(a_req), .steerCOMP(a_comp),
    .steer(a_steer), .owner(a_owner), .busy(a_busy), .err(a_err)
  );

  steer_sched #(.TMO(4), .FIXED_ORDER(1'b0)) dut_b (
    .clk(clk), .init(b_init), .req(b_req), .steerCOMP(b_comp),
    .steer(b_steer), .owner(b_owner), .busy(b_busy), .err(b_err)
  );

  steer_sched #(.TMO(20), .FIXED_ORDER(1'b1)) dut_c (
    .clk(clk), .init(c_init), .req(c_req), .steerCOMP(c_comp),
    .steer(c_steer), .owner(c_owner), .busy(c_busy), .err(c_err)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: one outstanding grant, which first awaits DATA ack then NULL ack.
  typedef struct {
    bit active;
    bit want_data;
    bit dead;
    int waited;
    int ptr;
    int owner;
  } mdl_t;

  function automatic mdl_t mdl_step(mdl_t m, logic init, logic [3:0] req, logic comp,
                                    bit fixed, int tmo);
    mdl_t r;
    int   pick;
    r    = m;
    pick = -1;
    if (init) begin
      r = '{default: 0};
    end else if (m.dead) begin
      r = m;
    end else if (!m.active) begin
      if (!comp) begin
        if (fixed) pick = m.ptr;
        else
          for (int k = 0; k < 4; k++)
            if (pick < 0 && req[(m.ptr + k) % 4]) pick = (m.ptr + k) % 4;
        if (pick >= 0) begin
          r.active    = 1'b1;
          r.want_data = 1'b1;
          r.waited    = 0;
          r.owner     = pick;
        end
      end
    end else if (comp == m.want_data) begin
      if (m.want_data) begin
        r.want_data = 1'b0;
        r.waited    = 0;
      end else begin
        r.active = 1'b0;
        r.ptr    = (m.owner + 1) % 4;
      end
    end else if (m.waited == tmo) begin
      r.dead   = 1'b1;
      r.active = 1'b0;
    end else begin
      r.waited = m.waited + 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] mdl_out(mdl_t m);
    logic [3:0] s;
    s = (m.active && m.want_data) ? 4'(1 << m.owner) : 4'd0;
    return {s, 2'(m.owner), m.active, m.dead};
  endfunction

  typedef struct {
    logic       init;
    logic [3:0] req;
    logic       comp;
    logic [3:0] steer;
    logic [1:0] owner;
    logic       busy;
    logic       err;
  } vec_t;

  vec_t vt[25];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mdl_t mb, mc;
    int   n;

    a_init = 1'b1; a_req = 4'd0; a_comp = 1'b0;
    b_init = 1'b1; b_req = 4'd0; b_comp = 1'b0;
    c_init = 1'b1; c_req = 4'd0; c_comp = 1'b0;

    //        init req      comp steer    own  busy err
    vt[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0}; // reset
    vt[1]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0}; // single requester
    vt[2]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 4'b0100, 1'b1, 4'b0000, 2'd2, 1'b1, 1'b0}; // DATA ack
    vt[4]  = '{1'b0, 4'b0100, 1'b1, 4'b0000, 2'd2, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 4'b0100, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0}; // NULL ack
    vt[6]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0}; // regrant
    vt[7]  = '{1'b0, 4'b0100, 1'b1, 4'b0000, 2'd2, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 4'b0100, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 4'b0010, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0}; // stale DATA, no grant
    vt[10] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vt[11] = '{1'b0, 4'b1000, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0}; // req change ignored
    vt[12] = '{1'b0, 4'b1000, 1'b1, 4'b0000, 2'd1, 1'b1, 1'b0};
    vt[13] = '{1'b0, 4'b1000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0};
    vt[14] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    vt[15] = '{1'b0, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    vt[16] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0}; // init mid-DATA
    vt[17] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0}; // no grant under init
    vt[18] = '{1'b0, 4'b1110, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vt[19] = '{1'b0, 4'b1110, 1'b1, 4'b0000, 2'd1, 1'b1, 1'b0};
    vt[20] = '{1'b0, 4'b1110, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0};
    vt[21] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vt[22] = '{1'b1, 4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0}; // init while 0100
    vt[23] = '{1'b0, 4'b1100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0}; // ptr back to 0
    vt[24] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};

    tick();
    for (int i = 0; i < 25; i++) begin
      a_init = vt[i].init; a_req = vt[i].req; a_comp = vt[i].comp;
      tick();
      check($sformatf("vec%0d", i),
            {24'd0, a_steer, a_owner, a_busy, a_err},
            {24'd0, vt[i].steer, vt[i].owner, vt[i].busy, vt[i].err});
      $display("vec %0d: init=%b req=%b comp=%b -> steer=%b owner=%0d busy=%b err=%b",
               i, a_init, a_req, a_comp, a_steer, a_owner, a_busy, a_err);
    end

    // All four requesting, datapath answers after two cycles each way
    a_init = 1'b0; a_req = 4'b1111; a_comp = 1'b0;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (a_steer == 4'd0 && n < 10) begin tick(); n++; end
      check($sformatf("rr%0d_latency", g), n, 1);
      check($sformatf("rr%0d_steer", g), a_steer, 1 << (g % 4));
      check($sformatf("rr%0d_owner", g), a_owner, g % 4);
      $display("rr grant %0d: steer=%b owner=%0d", g, a_steer, a_owner);
      tick();
      check($sformatf("rr%0d_hold", g), a_steer, 1 << (g % 4));
      a_comp = 1'b1;
      n = 0;
      while (a_steer != 4'd0 && n < 10) begin tick(); n++; end
      check($sformatf("rr%0d_null", g), n, 1);
      tick();
      a_comp = 1'b0;
      n = 0;
      while (a_busy && n < 10) begin tick(); n++; end
      check($sformatf("rr%0d_idle", g), n, 1);
    end

    // Timeout in DATA with TMO=4
    b_init = 1'b1; tick(); b_init = 1'b0;
    check("tmo_reset_err", b_err, 0);
    b_req = 4'b0001; b_comp = 1'b0;
    tick();
    check("tmo_grant", b_steer, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("tmo_hold%0d", i), {b_steer, b_err}, {4'b0001, 1'b0});
    end
    tick();
    check("tmo_fire", {b_steer, b_busy, b_err}, {4'b0000, 1'b0, 1'b1});
    $display("timeout: steer=%b busy=%b err=%b", b_steer, b_busy, b_err);
    b_req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      b_comp = i[0];
      tick();
      check($sformatf("err_stuck%0d", i), {b_steer, b_busy, b_err}, {4'b0000, 1'b0, 1'b1});
    end
    b_init = 1'b1; b_comp = 1'b0; tick(); b_init = 1'b0;
    check("err_cleared", {b_steer, b_owner, b_busy, b_err}, 8'd0);

    // Acknowledge on the timeout edge wins, in both DATA and NULLW
    b_req = 4'b0010;
    tick();
    check("edge_grant", b_steer, 4'b0010);
    for (int i = 0; i < 4; i++) tick();
    check("edge_data_hold", b_steer, 4'b0010);
    b_comp = 1'b1;
    tick();
    check("edge_data_ack", {b_steer, b_busy, b_err}, {4'b0000, 1'b1, 1'b0});
    for (int i = 0; i < 4; i++) tick();
    check("edge_null_hold", {b_busy, b_err}, {1'b1, 1'b0});
    b_comp = 1'b0;
    tick();
    check("edge_null_ack", {b_busy, b_err}, {1'b0, 1'b0});
    tick();
    check("edge_regrant", b_steer, 4'b0010);
    $display("boundary handshake: regrant steer=%b err=%b", b_steer, b_err);

    // Fixed rotation ignores req
    c_init = 1'b1; tick(); c_init = 1'b0; c_comp = 1'b0;
    for (int k = 0; k < 8; k++) begin
      c_req = 4'($urandom);
      tick();
      check($sformatf("fix%0d_steer", k), c_steer, 1 << (k % 4));
      $display("fixed grant %0d: req=%b steer=%b", k, c_req, c_steer);
      c_comp = 1'b1; tick();
      check($sformatf("fix%0d_null", k), {c_steer, c_busy}, {4'b0000, 1'b1});
      c_comp = 1'b0; tick();
      check($sformatf("fix%0d_idle", k), {c_steer, c_busy}, {4'b0000, 1'b0});
    end
    c_comp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stale%0d", i), {c_steer, c_busy}, {4'b0000, 1'b0});
    end
    c_comp = 1'b0;
    tick();
    check("stale_release", c_steer, 4'b0001);

    // Randomized run of dut_b and dut_c against the reference model
    mb = '{default: 0};
    mc = '{default: 0};
    for (int cyc = 0; cyc < 1500; cyc++) begin
      b_init = (cyc == 0) || ($urandom_range(0, 24) == 0);
      c_init = (cyc == 0) || ($urandom_range(0, 24) == 0);
      b_req  = 4'($urandom);
      c_req  = 4'($urandom);
      if ($urandom_range(0, 2) == 0) b_comp = ~b_comp;
      if ($urandom_range(0, 7) == 0) c_comp = ~c_comp;
      @(posedge clk);
      mb = mdl_step(mb, b_init, b_req, b_comp, 1'b0, 4);
      mc = mdl_step(mc, c_init, c_req, c_comp, 1'b1, 20);
      #1;
      check($sformatf("rnd_b%0d", cyc), {24'd0, b_steer, b_owner, b_busy, b_err},
            {24'd0, mdl_out(mb)});
      check($sformatf("rnd_c%0d", cyc), {24'd0, c_steer, c_owner, c_busy, c_err},
            {24'd0, mdl_out(mc)});
      if (cyc % 100 == 0)
        $display("random cycle %0d: b steer=%b err=%b, c steer=%b err=%b",
                 cyc, b_steer, b_err, c_steer, c_err);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
